// File: rtl/tap_recorder.sv
// Tape-in decoder: times ear half-periods, recognises pilot/sync/data and writes each
// block to tape memory as a TAP image (2-byte length at the block base, then the data).
module tap_recorder #(
    parameter int PILOT_MIN   = 1800,
    parameter int PILOT_MAX   = 2600,
    parameter int PILOT_COUNT = 256,
    parameter int SYNC_MAX    = 795,
    parameter int BIT_THRESH  = 2565,
    parameter int GAP         = 350000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        record,
    input  logic        ear,
    output logic [15:0] tap_address,
    output logic [7:0]  tap_wdata,
    output logic        tap_we,
    output logic [7:0]  blocks,
    output logic        busy
);

    localparam int PCNT_W = $clog2(PILOT_COUNT + 1);
    localparam logic [19:0] WIDTH_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PILOT,
        S_SYNC,
        S_DATA,
        S_WLEN_LO,
        S_WLEN_HI
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          ear_sync_reg;
    logic                ear_prev_reg;
    logic [19:0]         width_reg, width_next;
    logic [PCNT_W-1:0]   pcnt_reg, pcnt_next;
    logic                timing_reg, timing_next;
    logic                half_reg, half_next;
    logic [19:0]         h1_reg, h1_next;
    logic [2:0]          bit_reg, bit_next;
    logic [7:0]          shift_reg, shift_next;
    logic [15:0]         len_reg, len_next;
    logic [15:0]         addr_reg, addr_next;
    logic [15:0]         base_reg, base_next;
    logic [7:0]          blocks_reg, blocks_next;
    logic [15:0]         wr_addr_reg, wr_addr_next;
    logic [7:0]          wr_data_reg, wr_data_next;
    logic                we_reg, we_next;

    logic                edge_det;
    logic                gap_hit;
    logic                h_pilot;
    logic                h_sync;
    logic [20:0]         bit_sum;
    logic                bit_val;
    logic [7:0]          byte_val;

    // width_reg holds the cycles since the last edge, so on an edge it is exactly H
    assign edge_det = ear_sync_reg[1] ^ ear_prev_reg;
    assign gap_hit  = !edge_det && (width_reg == 20'(GAP));
    assign h_pilot  = (width_reg >= 20'(PILOT_MIN)) && (width_reg <= 20'(PILOT_MAX));
    assign h_sync   = width_reg < 20'(SYNC_MAX);
    assign bit_sum  = {1'b0, h1_reg} + {1'b0, width_reg};
    assign bit_val  = bit_sum >= 21'(BIT_THRESH);
    assign byte_val = {shift_reg[6:0], bit_val};

    always_comb begin
        if (edge_det)
            width_next = 20'd1;
        else if (width_reg == WIDTH_MAX)
            width_next = width_reg;
        else
            width_next = width_reg + 20'd1;
    end

    always_comb begin
        state_next   = state_reg;
        pcnt_next    = pcnt_reg;
        timing_next  = timing_reg;
        half_next    = half_reg;
        h1_next      = h1_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        len_next     = len_reg;
        addr_next    = addr_reg;
        base_next    = base_reg;
        blocks_next  = blocks_reg;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        we_next      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (record) begin
                    state_next  = S_PILOT;
                    pcnt_next   = '0;
                    timing_next = 1'b0;
                end
            end
            S_PILOT: begin
                if (!record) begin
                    state_next = S_IDLE;
                end else if (gap_hit) begin
                    pcnt_next = '0;
                end else if (edge_det) begin
                    if (!timing_reg) begin
                        // first edge after arming only opens the timing window
                        timing_next = 1'b1;
                    end else if (h_pilot) begin
                        if (pcnt_reg != PCNT_W'(PILOT_COUNT))
                            pcnt_next = pcnt_reg + 1'b1;
                    end else if (h_sync && (pcnt_reg == PCNT_W'(PILOT_COUNT))) begin
                        state_next = S_SYNC;
                    end else begin
                        pcnt_next = '0;
                    end
                end
            end
            S_SYNC: begin
                if (!record) begin
                    state_next = S_IDLE;
                end else if (gap_hit) begin
                    state_next = S_PILOT;
                    pcnt_next  = '0;
                end else if (edge_det) begin
                    if (h_sync) begin
                        state_next = S_DATA;
                        bit_next   = 3'd7;
                        len_next   = '0;
                        half_next  = 1'b0;
                        addr_next  = base_reg + 16'd2;
                    end else begin
                        state_next = S_PILOT;
                        pcnt_next  = '0;
                    end
                end
            end
            S_DATA: begin
                if (!record || gap_hit) begin
                    // partial byte and unpaired half are simply dropped here
                    if (len_reg == 16'd0) begin
                        state_next = S_PILOT;
                        pcnt_next  = '0;
                    end else begin
                        state_next   = S_WLEN_LO;
                        we_next      = 1'b1;
                        wr_addr_next = base_reg;
                        wr_data_next = len_reg[7:0];
                    end
                end else if (edge_det) begin
                    if (!half_reg) begin
                        h1_next   = width_reg;
                        half_next = 1'b1;
                    end else begin
                        half_next  = 1'b0;
                        shift_next = byte_val;
                        if (bit_reg == 3'd0) begin
                            we_next      = 1'b1;
                            wr_addr_next = addr_reg;
                            wr_data_next = byte_val;
                            addr_next    = addr_reg + 16'd1;
                            len_next     = len_reg + 16'd1;
                            bit_next     = 3'd7;
                        end else begin
                            bit_next = bit_reg - 3'd1;
                        end
                    end
                end
            end
            S_WLEN_LO: begin
                state_next   = S_WLEN_HI;
                we_next      = 1'b1;
                wr_addr_next = base_reg + 16'd1;
                wr_data_next = len_reg[15:8];
            end
            S_WLEN_HI: begin
                base_next   = addr_reg;
                blocks_next = blocks_reg + 8'd1;
                pcnt_next   = '0;
                state_next  = record ? S_PILOT : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            ear_sync_reg <= '0;
            ear_prev_reg <= 1'b0;
            width_reg    <= '0;
            pcnt_reg     <= '0;
            timing_reg   <= 1'b0;
            half_reg     <= 1'b0;
            h1_reg       <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            len_reg      <= '0;
            addr_reg     <= '0;
            base_reg     <= '0;
            blocks_reg   <= '0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            we_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ear_sync_reg <= {ear_sync_reg[0], ear};
            ear_prev_reg <= ear_sync_reg[1];
            width_reg    <= width_next;
            pcnt_reg     <= pcnt_next;
            timing_reg   <= timing_next;
            half_reg     <= half_next;
            h1_reg       <= h1_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            len_reg      <= len_next;
            addr_reg     <= addr_next;
            base_reg     <= base_next;
            blocks_reg   <= blocks_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            we_reg       <= we_next;
        end
    end

    assign tap_address = wr_addr_reg;
    assign tap_wdata   = wr_data_reg;
    assign tap_we      = we_reg;
    assign blocks      = blocks_reg;
    assign busy        = (state_reg == S_SYNC) || (state_reg == S_DATA);

endmodule

// File: tb/tb_tap_recorder.sv
// Bench for tap_recorder with time-scaled tape widths; a byte-level model predicts every
// memory write (address, data, order) and a per-cycle process checks writes and hold behaviour.
module tb_tap_recorder;

    localparam int PILOT_W = 54;
    localparam int SYNC1_W = 16;
    localparam int SYNC2_W = 18;
    localparam int ZERO_W  = 21;
    localparam int ONE_W   = 43;
    localparam int GAP_C   = 500;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        record = 1'b0;
    logic        ear = 1'b0;
    logic [15:0] tap_address;
    logic [7:0]  tap_wdata;
    logic        tap_we;
    logic [7:0]  blocks;
    logic        busy;

    tap_recorder #(
        .PILOT_MIN  (45),
        .PILOT_MAX  (65),
        .PILOT_COUNT(16),
        .SYNC_MAX   (20),
        .BIT_THRESH (64),
        .GAP        (GAP_C)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .record     (record),
        .ear        (ear),
        .tap_address(tap_address),
        .tap_wdata  (tap_wdata),
        .tap_we     (tap_we),
        .blocks     (blocks),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    logic [7:0]  mem [0:65535];
    logic [15:0] last_a = '0;
    logic [7:0]  last_d = '0;
    logic [15:0] m_base = '0;
    logic [15:0] m_len = '0;
    logic [7:0]  m_blocks = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // every write must be the next one the model predicts; idle cycles must hold the bus
    always @(negedge clock) begin : cmp
        wr_t e;
        if (!reset_n) begin
            last_a = '0;
            last_d = '0;
        end else if (tap_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         tap_address, tap_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(tap_address), 32'(e.a));
                check("wr_data", 32'(tap_wdata), 32'(e.d));
            end
            mem[tap_address] = tap_wdata;
            last_a = tap_address;
            last_d = tap_wdata;
        end else begin
            check("hold_addr", 32'(tap_address), 32'(last_a));
            check("hold_data", 32'(tap_wdata), 32'(last_d));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic half(input int w);
        tick(w);
        ear = ~ear;
    endtask

    task automatic model_reset();
        m_base   = '0;
        m_len    = '0;
        m_blocks = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        record  = 1'b0;
        tick(3);
        model_reset();
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic arm();
        record = 1'b1;
        tick(3);
        ear = ~ear;
    endtask

    task automatic pilot_sync(input int n);
        for (int i = 0; i < n; i++) half(PILOT_W);
        half(SYNC1_W);
        half(SYNC2_W);
        m_len = '0;
    endtask

    task automatic send_bit(input logic v, input logic jit, input int k);
        int w1;
        int w2;
        if (!jit) begin
            w1 = v ? ONE_W : ZERO_W;
            w2 = w1;
        end else if (v) begin
            w1 = k[0] ? 39 : 47;
            w2 = k[0] ? 47 : 39;
        end else begin
            w1 = k[0] ? 19 : 23;
            w2 = k[0] ? 23 : 19;
        end
        half(w1);
        half(w2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic jit);
        wr_t w;
        w.a = m_base + 16'd2 + m_len;
        w.d = b;
        exp_q.push_back(w);
        m_len = m_len + 16'd1;
        for (int i = 7; i >= 0; i--) send_bit(b[i], jit, i);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i], 1'b0, i);
    endtask

    // a closed block adds its length at base/base+1 and moves base past the image
    task automatic model_close();
        wr_t w;
        if (m_len != 16'd0) begin
            w.a = m_base;
            w.d = m_len[7:0];
            exp_q.push_back(w);
            w.a = m_base + 16'd1;
            w.d = m_len[15:8];
            exp_q.push_back(w);
            m_base   = m_base + m_len + 16'd2;
            m_blocks = m_blocks + 8'd1;
            m_len    = '0;
        end
    endtask

    task automatic gap_end();
        model_close();
        tick(GAP_C + 20);
        check("blocks_model", 32'(blocks), 32'(m_blocks));
        check("busy_after_gap", 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_addr", 32'(tap_address), 32'd0);
        check("rst_data", 32'(tap_wdata), 32'd0);
        check("rst_we", 32'(tap_we), 32'd0);
        check("rst_blocks", 32'(blocks), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // three-byte block, including write latency relative to the last ear edge
        arm();
        pilot_sync(20);
        tick(3);
        check("busy_data", 32'(busy), 32'd1);
        send_byte(8'hFF, 1'b0);
        tick(2);
        check("lat_2cyc_we", 32'(tap_we), 32'd0);
        tick(1);
        check("lat_3cyc_we", 32'(tap_we), 32'd1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        gap_end();
        check("t1_mem0", 32'(mem[0]), 32'h03);
        check("t1_mem1", 32'(mem[1]), 32'h00);
        check("t1_mem2", 32'(mem[2]), 32'hFF);
        check("t1_mem3", 32'(mem[3]), 32'h01);
        check("t1_mem4", 32'(mem[4]), 32'h02);
        check("t1_blocks", 32'(blocks), 32'd1);

        // two consecutive blocks
        do_reset();
        arm();
        pilot_sync(20);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'(i * 7 + 3), 1'b0);
        gap_end();
        pilot_sync(20);
        send_byte(8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 1'b0);
        gap_end();
        check("t2_len1_lo", 32'(mem[16'h0000]), 32'h11);
        check("t2_len2_lo", 32'(mem[16'h0013]), 32'h06);
        check("t2_len2_hi", 32'(mem[16'h0014]), 32'h00);
        check("t2_data2", 32'(mem[16'h0015]), 32'hFF);
        check("t2_blocks", 32'(blocks), 32'd2);

        // short pilot: sync must be rejected, then a full pilot works
        do_reset();
        arm();
        pilot_sync(12);
        tick(4);
        check("t3_rejected_busy", 32'(busy), 32'd0);
        pilot_sync(20);
        send_byte(8'hA5, 1'b0);
        gap_end();
        check("t3_mem0", 32'(mem[0]), 32'h01);
        check("t3_mem2", 32'(mem[2]), 32'hA5);

        // five bits only: nothing written, recorder stays in pilot search
        do_reset();
        arm();
        pilot_sync(20);
        send_bits(8'hB0, 5);
        gap_end();
        check("t4_blocks", 32'(blocks), 32'd0);
        pilot_sync(20);
        send_byte(8'h5C, 1'b0);
        gap_end();
        check("t4_mem2", 32'(mem[2]), 32'h5C);

        // jittered halves
        do_reset();
        arm();
        pilot_sync(20);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h0F, 1'b1);
        gap_end();
        check("t5_mem2", 32'(mem[2]), 32'h5A);
        check("t5_mem3", 32'(mem[3]), 32'hC3);
        check("t5_mem4", 32'(mem[4]), 32'h0F);

        // record dropped after two bytes, then reset in the middle of a block
        do_reset();
        arm();
        pilot_sync(20);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        tick(5);
        model_close();
        record = 1'b0;
        tick(10);
        check("t6_mem0", 32'(mem[0]), 32'h02);
        check("t6_mem1", 32'(mem[1]), 32'h00);
        check("t6_blocks", 32'(blocks), 32'd1);
        check("t6_busy_idle", 32'(busy), 32'd0);
        arm();
        pilot_sync(20);
        send_byte(8'h81, 1'b0);
        send_bits(8'hF0, 4);
        reset_n = 1'b0;
        record  = 1'b0;
        tick(2);
        check("midrst_addr", 32'(tap_address), 32'd0);
        check("midrst_data", 32'(tap_wdata), 32'd0);
        check("midrst_we", 32'(tap_we), 32'd0);
        check("midrst_blocks", 32'(blocks), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pending", 32'(exp_q.size()), 32'd0);
        model_reset();
        tick(1);
        reset_n = 1'b1;
        tick(2);
        arm();
        pilot_sync(20);
        send_byte(8'h3C, 1'b0);
        gap_end();
        check("t6_rebase_mem0", 32'(mem[0]), 32'h01);
        check("t6_rebase_mem2", 32'(mem[2]), 32'h3C);

        tick(5);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
